hack_vector_checker: RTL and testbench
======================================

Name: hack_vector_checker

Overview:
- Synthesizable response checker for the Hack gate library: the reading end of the stimulus/response flow that bench stimulus drivers write.
- Holds a table of expected vectors and masks, samples the DUT's observed bus once every STEP clock cycles, and compares each sample against the next expected entry.
- Reports pass/fail, mismatch count and index of the first failing vector, so gate benches can self-check instead of relying on offline text diffs.

Parameters:
- WIDTH, 2, width of one observed vector (e.g. {in,out} for a 1-input gate).
- DEPTH, 16, number of expected-vector entries; power of two, ≥2.
- STEP, 4, clock cycles between samples; ≥1.
- AW, $clog2(DEPTH), derived index width; not overridden.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- load_we  input  1  write enable for the expected table.
- load_addr  input  AW  table write index.
- load_data  input  WIDTH  expected value.
- load_mask  input  WIDTH  care mask; 1 = compare the bit, 0 = ignore it.
- n_vectors  input  AW+1  number of vectors to check; latched at start.
- start  input  1  single-cycle pulse that begins a run.
- observed  input  WIDTH  DUT response bus being checked.
- busy  output  1  high while a run is in progress.
- done  output  1  high after a run completes; held until the next start or reset.
- pass  output  1  valid when done=1; 1 = zero mismatches.
- err_count  output  AW+1  number of mismatching vectors.
- first_err_idx  output  AW  index of the first mismatch; 0 if none.
- vec_idx  output  AW  index of the vector currently being awaited.

Behaviour:
- Decided: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset values: busy=0, done=0, pass=0, err_count=0, first_err_idx=0, vec_idx=0, timer=0, state=IDLE.
- Reset does not clear the expected table; contents are retained.
- Table write: when load_we=1 and state≠RUN, the entry at load_addr is written with {load_mask, load_data}. load_we is ignored while in RUN.
- Compare: a vector matches iff ((observed ^ data) & mask) == 0. A mask of all zeros always matches.
- State IDLE:
  - On start: latch N = min(n_vectors, DEPTH); clear err_count, first_err_idx, vec_idx and pass; clear done.
  - If N==0, go to DONE with pass=1.
  - Otherwise load timer=STEP-1, set busy=1, go to RUN.
- State RUN:
  - Each cycle with timer>0: decrement timer.
  - Cycle with timer==0: sample observed and compare against entry vec_idx in that cycle (combinational table read).
  - On mismatch: increment err_count; if err_count was 0, set first_err_idx=vec_idx.
  - If vec_idx==N-1: go to DONE. Otherwise increment vec_idx and reload timer=STEP-1.
- Sample timing: with start sampled at edge E0, vector k is sampled at edge E0+(k+1)*STEP. Total run length is N*STEP cycles.
- State DONE:
  - busy=0, done=1, pass = (err_count==0).
  - A start here behaves exactly like a start in IDLE (restart).
- start while in RUN is ignored.
- Reset asserted in any state, including mid-run, aborts the run and applies the reset values on the next edge. Reset has priority over start and load_we.
- Widths: err_count never exceeds DEPTH, so no saturation logic is needed. vec_idx never wraps within a run.
- STEP=1: one sample per cycle, no idle gap between samples.

Test Plan:
- Not-gate table, STEP=4, N=2, entries {in,out}={01,10}, masks 11; drive observed=01 then 10, each stable across its sample edge -> done=1 at E0+8, pass=1, err_count=0.
- Same table, observed=00 at sample 0 and 10 at sample 1 -> pass=0, err_count=1, first_err_idx=0.
- Mask test: entry 0 data=11 mask=10, observed=10 -> counted as a match. DEPTH=16, N=20 with all entries masked 00 -> N clamps to 16, done at E0+64, pass=1.
- N=0 start -> done=1 and pass=1 on the next edge, busy never asserted.
- Reset mid-run after the 1st sample with err_count=1 -> all outputs return to reset values. Then start with the correct observed values -> pass=1, proving the table was retained.
- start and load_we pulsed during RUN -> run timing unchanged, table entry unchanged. start in DONE -> new run begins and done drops on the next edge.

Source files
------------

// File: rtl/hack_vector_checker.sv
// Response checker for Hack gate benches: samples the observed bus every STEP
// cycles and compares each sample against a masked table of expected vectors.
module hack_vector_checker #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 16,
    parameter int STEP  = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_we,
    input  logic [AW-1:0]    load_addr,
    input  logic [WIDTH-1:0] load_data,
    input  logic [WIDTH-1:0] load_mask,
    input  logic [AW:0]      n_vectors,
    input  logic             start,
    input  logic [WIDTH-1:0] observed,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [AW:0]      err_count,
    output logic [AW-1:0]    first_err_idx,
    output logic [AW-1:0]    vec_idx
);

    localparam int TW = (STEP > 1) ? $clog2(STEP) : 1;
    localparam logic [TW-1:0] STEP_M1 = TW'(STEP - 1);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);
    localparam logic [AW:0] DEPTH_N = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_N = (AW + 1)'(1);
    localparam logic [AW-1:0] ONE_IDX = AW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Masked compare: only bits with mask=1 can cause a mismatch.
    function automatic logic vec_mismatch(input logic [WIDTH-1:0] obs,
                                          input logic [WIDTH-1:0] data,
                                          input logic [WIDTH-1:0] mask);
        return |((obs ^ data) & mask);
    endfunction

    logic [2*WIDTH-1:0] exp_mem_r [DEPTH];
    logic [2*WIDTH-1:0] entry_s;
    logic               mismatch_s;

    state_t        state_r, state_s;
    logic [TW-1:0] timer_r, timer_s;
    logic [AW-1:0] vec_idx_r, vec_idx_s;
    logic [AW:0]   n_r, n_s;
    logic [AW:0]   err_r, err_s;
    logic [AW-1:0] fidx_r, fidx_s;
    logic          pass_r, pass_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;

    assign entry_s    = exp_mem_r[vec_idx_r];
    assign mismatch_s = vec_mismatch(observed, entry_s[WIDTH-1:0], entry_s[2*WIDTH-1:WIDTH]);

    // Expected table write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (load_we && (state_r != RUN)) begin
            exp_mem_r[load_addr] <= {load_mask, load_data};
        end
    end

    // Next-state and next-output logic for the run sequencer.
    always_comb begin
        state_s   = state_r;
        timer_s   = timer_r;
        vec_idx_s = vec_idx_r;
        n_s       = n_r;
        err_s     = err_r;
        fidx_s    = fidx_r;
        pass_s    = pass_r;
        busy_s    = busy_r;
        done_s    = done_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    n_s       = (n_vectors > DEPTH_N) ? DEPTH_N : n_vectors;
                    err_s     = '0;
                    fidx_s    = '0;
                    vec_idx_s = '0;
                    pass_s    = 1'b0;
                    done_s    = 1'b0;
                    if (n_s == '0) begin
                        state_s = DONE;
                        pass_s  = 1'b1;
                        done_s  = 1'b1;
                        busy_s  = 1'b0;
                    end else begin
                        state_s = RUN;
                        timer_s = STEP_M1;
                        busy_s  = 1'b1;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            RUN: begin
                if (timer_r != '0) begin
                    timer_s = timer_r - TIMER_ONE;
                end else begin
                    if (mismatch_s) begin
                        err_s  = err_r + ONE_N;
                        fidx_s = (err_r == '0) ? vec_idx_r : fidx_r;
                    end else begin
                        err_s = err_r;
                    end
                    // vec_idx stays on the last vector so it never wraps.
                    if ({1'b0, vec_idx_r} == (n_r - ONE_N)) begin
                        state_s = DONE;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        pass_s  = (err_s == '0);
                    end else begin
                        vec_idx_s = vec_idx_r + ONE_IDX;
                        timer_s   = STEP_M1;
                    end
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
                done_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            timer_r   <= '0;
            vec_idx_r <= '0;
            n_r       <= '0;
            err_r     <= '0;
            fidx_r    <= '0;
            pass_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            timer_r   <= timer_s;
            vec_idx_r <= vec_idx_s;
            n_r       <= n_s;
            err_r     <= err_s;
            fidx_r    <= fidx_s;
            pass_r    <= pass_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign err_count     = err_r;
    assign first_err_idx = fidx_r;
    assign vec_idx       = vec_idx_r;

endmodule

// File: tb/tb_hack_vector_checker.sv
// Directed bench for hack_vector_checker: a reference model fills a result
// scoreboard at each start, and results are popped when the run finishes.
module tb_hack_vector_checker;

    localparam int WIDTH = 2;
    localparam int DEPTH = 16;
    localparam int STEP  = 4;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             load_we;
    logic [AW-1:0]    load_addr;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] load_mask;
    logic [AW:0]      n_vectors;
    logic             start;
    logic [WIDTH-1:0] observed;
    logic             busy;
    logic             done;
    logic             pass;
    logic [AW:0]      err_count;
    logic [AW-1:0]    first_err_idx;
    logic [AW-1:0]    vec_idx;

    hack_vector_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STEP(STEP)) dut (
        .clk(clk), .reset(reset), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .load_mask(load_mask), .n_vectors(n_vectors),
        .start(start), .observed(observed), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .first_err_idx(first_err_idx),
        .vec_idx(vec_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          pass;
        logic [AW:0]   errc;
        logic [AW-1:0] fidx;
    } res_t;

    res_t             sb[$];
    logic [WIDTH-1:0] md [DEPTH];
    logic [WIDTH-1:0] mm [DEPTH];
    logic [WIDTH-1:0] obs_v [DEPTH];
    int               checks = 0;
    int               errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        assert (act === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, expv);
        end
    endtask

    task automatic load(input int addr, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] m);
        load_we   = 1'b1;
        load_addr = AW'(addr);
        load_data = d;
        load_mask = m;
        md[addr]  = d;
        mm[addr]  = m;
        tick();
        load_we   = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
        chk({tag, "_errc"}, 32'(err_count), 32'd0);
        chk({tag, "_fidx"}, 32'(first_err_idx), 32'd0);
        chk({tag, "_vidx"}, 32'(vec_idx), 32'd0);
    endtask

    // Runs n vectors with obs_v[k] stable across sample edge E0+(k+1)*STEP;
    // disturb=1 pulses start and a corrupting load_we in the middle of the run.
    task automatic run(input string tag, input int n, input bit disturb);
        int   nn;
        int   e;
        int   f;
        res_t r;
        res_t got;
        nn = (n > DEPTH) ? DEPTH : n;
        e  = 0;
        f  = 0;
        for (int k = 0; k < nn; k++) begin
            if (((obs_v[k] ^ md[k]) & mm[k]) != '0) begin
                if (e == 0) f = k;
                e++;
            end
        end
        r.pass = (e == 0);
        r.errc = (AW + 1)'(e);
        r.fidx = AW'(f);
        sb.push_back(r);

        observed  = obs_v[0];
        n_vectors = (AW + 1)'(n);
        start     = 1'b1;
        tick();
        start = 1'b0;
        if (nn == 0) begin
            chk({tag, "_busy0"}, 32'(busy), 32'd0);
            chk({tag, "_done0"}, 32'(done), 32'd1);
        end else begin
            chk({tag, "_done_clr"}, 32'(done), 32'd0);
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            for (int c = 1; c < nn * STEP; c++) begin
                if (disturb && c == 2) begin
                    start     = 1'b1;
                    load_we   = 1'b1;
                    load_addr = AW'(1);
                    load_data = ~md[1];
                    load_mask = '1;
                end
                tick();
                start   = 1'b0;
                load_we = 1'b0;
                if (c % STEP == 0) observed = obs_v[c / STEP];
            end
            chk({tag, "_not_yet"}, 32'(done), 32'd0);
            tick();
            chk({tag, "_done"}, 32'(done), 32'd1);
            chk({tag, "_busy_end"}, 32'(busy), 32'd0);
            chk({tag, "_vidx_end"}, 32'(vec_idx), 32'(nn - 1));
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
        end else begin
            got = sb.pop_front();
            chk({tag, "_pass"}, 32'(pass), 32'(got.pass));
            chk({tag, "_errc"}, 32'(err_count), 32'(got.errc));
            chk({tag, "_fidx"}, 32'(first_err_idx), 32'(got.fidx));
        end
    endtask

    initial begin
        reset     = 1'b1;
        load_we   = 1'b0;
        load_addr = '0;
        load_data = '0;
        load_mask = '0;
        n_vectors = '0;
        start     = 1'b0;
        observed  = '0;
        tick();
        tick();
        reset = 1'b0;
        chk_reset_values("rst");

        // Not-gate table {in,out}
        load(0, 2'b01, 2'b11);
        load(1, 2'b10, 2'b11);
        load(2, 2'b01, 2'b11);
        obs_v[0] = 2'b01; obs_v[1] = 2'b10;
        run("not_ok", 2, 1'b0);
        obs_v[0] = 2'b00; obs_v[1] = 2'b10;
        run("not_err0", 2, 1'b0);
        obs_v[0] = 2'b01; obs_v[1] = 2'b00; obs_v[2] = 2'b00;
        run("not_err12", 3, 1'b0);

        // Partial mask: only bit 1 is compared
        load(0, 2'b11, 2'b10);
        obs_v[0] = 2'b10;
        run("mask_ok", 1, 1'b0);
        obs_v[0] = 2'b01;
        run("mask_err", 1, 1'b0);

        // All entries don't-care, N clamps to DEPTH
        for (int i = 0; i < DEPTH; i++) begin
            load(i, 2'($urandom_range(0, 3)), 2'b00);
            obs_v[i] = 2'($urandom_range(0, 3));
        end
        run("clamp", 20, 1'b0);

        run("n0", 0, 1'b0);

        // Reset mid-run after one failing sample
        load(0, 2'b01, 2'b11);
        load(1, 2'b10, 2'b11);
        observed  = 2'b00;
        n_vectors = 5'd2;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (STEP) tick();
        chk("mid_errc", 32'(err_count), 32'd1);
        chk("mid_vidx", 32'(vec_idx), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_values("abort");
        obs_v[0] = 2'b01; obs_v[1] = 2'b10;
        run("retained", 2, 1'b0);

        // start and load_we during RUN must be ignored
        run("disturb", 2, 1'b1);
        run("unchanged", 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
